dmem_bus_ctrl: RTL



---
 rtl/dmem_bus_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns a memory-stage load/store request into one
// valid/ready bus transaction and stalls the pipeline until it completes or times out.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        stall,
    output logic [31:0] data_loaded,
    output logic        bus_err,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] data_loaded_q, data_loaded_d;
    logic        bus_err_q, bus_err_d;
    logic        req;

    assign req = req_rd | req_wr;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_valid_d   = bus_valid_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        data_loaded_d = data_loaded_q;
        bus_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    bus_addr_d  = {req_addr[31:2], 2'b00};
                    bus_wdata_d = req_wdata;
                    bus_we_d    = req_wr;
                    bus_be_d    = req_wr ? req_mask : 4'b1111;
                    cnt_d       = 8'd0;
                    // An all-disabled store has nothing to put on the bus.
                    if (req_wr && (req_mask == 4'b0000)) begin
                        state_d = DONE;
                    end else begin
                        state_d     = BUSY;
                        bus_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (bus_ready) begin
                    if (!bus_we_q) begin
                        data_loaded_d = bus_rdata;
                    end
                    cnt_d       = 8'd0;
                    bus_valid_d = 1'b0;
                    state_d     = DONE;
                end else if (cnt_q == TO_LAST) begin
                    if (!bus_we_q) begin
                        data_loaded_d = 32'd0;
                    end
                    cnt_d       = 8'd0;
                    bus_valid_d = 1'b0;
                    bus_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            bus_be_q      <= 4'b0000;
            data_loaded_q <= 32'd0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_valid_q   <= bus_valid_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            data_loaded_q <= data_loaded_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // DONE is the cycle in which the pipeline is released.
    assign stall       = req & (state_q != DONE);
    assign data_loaded = data_loaded_q;
    assign bus_err     = bus_err_q;
    assign bus_valid   = bus_valid_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_be      = bus_be_q;

endmodule
